// File: rtl/mem_axi_arbiter_pkg.sv
// Shared widths and encodings for the core-side memory arbiter.
// Width constants are common to the core; state and source encodings are local to the arbiter.
package mem_axi_arbiter_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int MEM_MASK_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_1 = 1'b0,
    SRC_2 = 1'b1
  } src_t;

endpackage

// File: rtl/mem_axi_arbiter.sv
// Fixed-priority arbiter (store > load > fetch) onto one AXI4-Lite master, one transaction at a time.
// Min latency: request seen -> valid next cycle -> handshake -> finish pulse; AXI stalls simply extend RD/WR.
module mem_axi_arbiter
  import mem_axi_arbiter_pkg::*;
#(
  parameter int XLEN   = ISA_WIDTH,
  parameter int MASK_W = MEM_MASK_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   mem_1_r,
  input  logic [XLEN-1:0]   mem_1_addr,
  input  logic              mem_1_r_en,
  output logic              mem_1_finish,
  output logic [XLEN-1:0]   mem_2_r,
  input  logic [XLEN-1:0]   mem_2_w,
  input  logic [XLEN-1:0]   mem_2_addr,
  input  logic [MASK_W-1:0] mem_2_mask,
  input  logic              mem_2_r_en,
  input  logic              mem_2_w_en,
  output logic              mem_2_finish,
  output logic [XLEN-1:0]   axi_araddr,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [XLEN-1:0]   axi_rdata,
  input  logic [XLEN-1:0]   axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready,
  output logic [XLEN-1:0]   axi_awaddr,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [XLEN-1:0]   axi_wdata,
  output logic [MASK_W-1:0] axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [XLEN-1:0]   axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready
);

  state_t state, state_nxt;
  src_t   src;

  logic ar_hs, r_hs, aw_ok, w_ok, b_hs;
  logic resp_unused;

  // Responses are deliberately not inspected.
  assign resp_unused = ^{axi_rresp, axi_bresp};

  assign ar_hs = axi_arvalid & axi_arready;
  assign r_hs  = axi_rvalid & axi_rready;
  // In WR a channel's valid only drops after its handshake, so a low valid means "done".
  assign aw_ok = ~axi_awvalid | axi_awready;
  assign w_ok  = ~axi_wvalid | axi_wready;
  assign b_hs  = axi_bvalid & axi_bready & aw_ok & w_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_2_w_en)                    state_nxt = WR;
        else if (mem_2_r_en || mem_1_r_en) state_nxt = RD;
      end
      RD:      if (r_hs) state_nxt = FIN;
      WR:      if (b_hs) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src          <= SRC_1;
      mem_1_r      <= '0;
      mem_2_r      <= '0;
      mem_1_finish <= 1'b0;
      mem_2_finish <= 1'b0;
      axi_araddr   <= '0;
      axi_arvalid  <= 1'b0;
      axi_rready   <= 1'b0;
      axi_awaddr   <= '0;
      axi_awvalid  <= 1'b0;
      axi_wdata    <= '0;
      axi_wstrb    <= '0;
      axi_wvalid   <= 1'b0;
      axi_bready   <= 1'b0;
    end else begin
      mem_1_finish <= 1'b0;
      mem_2_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_2_w_en) begin
            src         <= SRC_2;
            axi_awaddr  <= mem_2_addr;
            axi_wdata   <= mem_2_w;
            axi_wstrb   <= mem_2_mask;
            axi_awvalid <= 1'b1;
            axi_wvalid  <= 1'b1;
            axi_bready  <= 1'b1;
          end else if (mem_2_r_en) begin
            src         <= SRC_2;
            axi_araddr  <= mem_2_addr;
            axi_arvalid <= 1'b1;
            axi_rready  <= 1'b1;
          end else if (mem_1_r_en) begin
            src         <= SRC_1;
            axi_araddr  <= mem_1_addr;
            axi_arvalid <= 1'b1;
            axi_rready  <= 1'b1;
          end
        end
        RD: begin
          if (ar_hs) axi_arvalid <= 1'b0;
          if (r_hs) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            if (src == SRC_2) mem_2_r <= axi_rdata;
            else              mem_1_r <= axi_rdata;
            mem_1_finish <= (src == SRC_1);
            mem_2_finish <= (src == SRC_2);
          end
        end
        WR: begin
          if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
          if (axi_wvalid && axi_wready)   axi_wvalid  <= 1'b0;
          if (b_hs) begin
            axi_awvalid  <= 1'b0;
            axi_wvalid   <= 1'b0;
            axi_bready   <= 1'b0;
            mem_2_finish <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter: each task drives a scenario cycle by cycle and checks inline.
module tb_mem_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_1_r, mem_1_addr;
  logic        mem_1_r_en, mem_1_finish;
  logic [31:0] mem_2_r, mem_2_w, mem_2_addr;
  logic [3:0]  mem_2_mask;
  logic        mem_2_r_en, mem_2_w_en, mem_2_finish;
  logic [31:0] axi_araddr, axi_rdata, axi_rresp, axi_awaddr, axi_wdata, axi_bresp;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [3:0]  axi_wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .mem_1_r(mem_1_r), .mem_1_addr(mem_1_addr), .mem_1_r_en(mem_1_r_en), .mem_1_finish(mem_1_finish),
    .mem_2_r(mem_2_r), .mem_2_w(mem_2_w), .mem_2_addr(mem_2_addr), .mem_2_mask(mem_2_mask),
    .mem_2_r_en(mem_2_r_en), .mem_2_w_en(mem_2_w_en), .mem_2_finish(mem_2_finish),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mem_1_addr = '0; mem_1_r_en = 1'b0;
    mem_2_w = '0; mem_2_addr = '0; mem_2_mask = '0; mem_2_r_en = 1'b0; mem_2_w_en = 1'b0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rvalid = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = '0; axi_bvalid = 1'b0;
    rst = 1'b1;
    tick; tick;
    total++; if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0) begin
      bad++; $display("FAIL reset_valids got=%b exp=00000", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}); end
    total++; if ({mem_1_finish, mem_2_finish} !== 2'b0) begin
      bad++; $display("FAIL reset_finish got=%b exp=00", {mem_1_finish, mem_2_finish}); end
    total++; if ({mem_1_r, mem_2_r} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {mem_1_r, mem_2_r}); end
    total++; if ({axi_araddr, axi_awaddr, axi_wdata, axi_wstrb} !== 100'h0) begin
      bad++; $display("FAIL reset_addr_data got=%h exp=0", {axi_araddr, axi_awaddr, axi_wdata, axi_wstrb}); end
    rst = 1'b0;
    tick;
    total++; if ({axi_arvalid, axi_awvalid, mem_1_finish, mem_2_finish} !== 4'b0) begin
      bad++; $display("FAIL reset_idle got=%b exp=0000", {axi_arvalid, axi_awvalid, mem_1_finish, mem_2_finish}); end
  endtask

  task automatic test_fetch();
    mem_1_addr = 32'h8000_0000; mem_1_r_en = 1'b1;
    tick;
    total++; if (axi_arvalid !== 1'b1) begin bad++; $display("FAIL fetch_arvalid got=%b exp=1", axi_arvalid); end
    total++; if (axi_araddr !== 32'h8000_0000) begin bad++; $display("FAIL fetch_araddr got=%h exp=80000000", axi_araddr); end
    total++; if (axi_rready !== 1'b1) begin bad++; $display("FAIL fetch_rready got=%b exp=1", axi_rready); end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (axi_arvalid !== 1'b1) begin bad++; $display("FAIL fetch_ar_hold%0d got=%b exp=1", i, axi_arvalid); end
    end
    axi_arready = 1'b1;
    tick;
    axi_arready = 1'b0;
    total++; if (axi_arvalid !== 1'b0) begin bad++; $display("FAIL fetch_ar_drop got=%b exp=0", axi_arvalid); end
    total++; if (mem_1_finish !== 1'b0) begin bad++; $display("FAIL fetch_early_finish got=%b exp=0", mem_1_finish); end
    axi_rdata = 32'h0010_0073; axi_rvalid = 1'b1;
    tick;
    axi_rvalid = 1'b0; axi_rdata = 32'hFFFF_FFFF;
    total++; if (mem_1_finish !== 1'b1) begin bad++; $display("FAIL fetch_finish got=%b exp=1", mem_1_finish); end
    total++; if (mem_1_r !== 32'h0010_0073) begin bad++; $display("FAIL fetch_rdata got=%h exp=00100073", mem_1_r); end
    total++; if (mem_2_finish !== 1'b0) begin bad++; $display("FAIL fetch_p2_finish got=%b exp=0", mem_2_finish); end
    total++; if (axi_rready !== 1'b0) begin bad++; $display("FAIL fetch_rready_drop got=%b exp=0", axi_rready); end
    mem_1_r_en = 1'b0;
    tick;
    total++; if (mem_1_finish !== 1'b0) begin bad++; $display("FAIL fetch_pulse_len got=%b exp=0", mem_1_finish); end
    total++; if (mem_1_r !== 32'h0010_0073) begin bad++; $display("FAIL fetch_rdata_held got=%h exp=00100073", mem_1_r); end
  endtask

  task automatic test_load();
    mem_2_addr = 32'h8000_1004; mem_2_r_en = 1'b1;
    tick;
    total++; if (axi_araddr !== 32'h8000_1004) begin bad++; $display("FAIL load_araddr got=%h exp=80001004", axi_araddr); end
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h1234_ABCD;
    tick;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0;
    total++; if (mem_2_finish !== 1'b1) begin bad++; $display("FAIL load_finish got=%b exp=1", mem_2_finish); end
    total++; if (mem_2_r !== 32'h1234_ABCD) begin bad++; $display("FAIL load_rdata got=%h exp=1234abcd", mem_2_r); end
    total++; if (mem_1_r !== 32'h0010_0073) begin bad++; $display("FAIL load_p1_unchanged got=%h exp=00100073", mem_1_r); end
    total++; if ({mem_1_finish, axi_arvalid} !== 2'b00) begin bad++; $display("FAIL load_quiet got=%b exp=00", {mem_1_finish, axi_arvalid}); end
    mem_2_r_en = 1'b0;
    tick;
    total++; if (mem_2_finish !== 1'b0) begin bad++; $display("FAIL load_pulse_len got=%b exp=0", mem_2_finish); end
  endtask

  task automatic test_store();
    // read enable also raised: write must win
    mem_2_addr = 32'h8000_1004; mem_2_w = 32'hDEAD_BEEF; mem_2_mask = 4'b0011;
    mem_2_w_en = 1'b1; mem_2_r_en = 1'b1;
    tick;
    total++; if ({axi_awvalid, axi_wvalid, axi_arvalid} !== 3'b110) begin
      bad++; $display("FAIL store_valids got=%b exp=110", {axi_awvalid, axi_wvalid, axi_arvalid}); end
    total++; if (axi_awaddr !== 32'h8000_1004) begin bad++; $display("FAIL store_awaddr got=%h exp=80001004", axi_awaddr); end
    total++; if (axi_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_wdata got=%h exp=deadbeef", axi_wdata); end
    total++; if (axi_wstrb !== 4'b0011) begin bad++; $display("FAIL store_wstrb got=%b exp=0011", axi_wstrb); end
    total++; if (axi_bready !== 1'b1) begin bad++; $display("FAIL store_bready got=%b exp=1", axi_bready); end
    axi_wready = 1'b1;
    tick;
    axi_wready = 1'b0;
    total++; if ({axi_awvalid, axi_wvalid} !== 2'b10) begin bad++; $display("FAIL store_w_drop got=%b exp=10", {axi_awvalid, axi_wvalid}); end
    axi_bvalid = 1'b1;
    tick;
    axi_bvalid = 1'b0;
    total++; if ({mem_2_finish, axi_bready, axi_awvalid} !== 3'b011) begin
      bad++; $display("FAIL store_early_b got=%b exp=011", {mem_2_finish, axi_bready, axi_awvalid}); end
    tick;
    total++; if (axi_awvalid !== 1'b1) begin bad++; $display("FAIL store_aw_hold got=%b exp=1", axi_awvalid); end
    axi_awready = 1'b1;
    tick;
    axi_awready = 1'b0;
    total++; if ({axi_awvalid, axi_bready, mem_2_finish} !== 3'b010) begin
      bad++; $display("FAIL store_aw_drop got=%b exp=010", {axi_awvalid, axi_bready, mem_2_finish}); end
    axi_bvalid = 1'b1;
    tick;
    axi_bvalid = 1'b0;
    total++; if ({mem_2_finish, mem_1_finish, axi_bready} !== 3'b100) begin
      bad++; $display("FAIL store_finish got=%b exp=100", {mem_2_finish, mem_1_finish, axi_bready}); end
    total++; if (mem_2_r !== 32'h1234_ABCD) begin bad++; $display("FAIL store_p2r_unchanged got=%h exp=1234abcd", mem_2_r); end
    mem_2_w_en = 1'b0; mem_2_r_en = 1'b0;
    tick;
    total++; if ({mem_2_finish, axi_awvalid, axi_wvalid, axi_arvalid} !== 4'b0) begin
      bad++; $display("FAIL store_after got=%b exp=0000", {mem_2_finish, axi_awvalid, axi_wvalid, axi_arvalid}); end
  endtask

  task automatic test_contention();
    mem_1_addr = 32'h8000_0100; mem_2_addr = 32'h8000_2000;
    mem_1_r_en = 1'b1; mem_2_r_en = 1'b1;
    tick;
    total++; if (axi_araddr !== 32'h8000_2000) begin bad++; $display("FAIL cont_first_addr got=%h exp=80002000", axi_araddr); end
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'hAAAA_5555;
    tick;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    total++; if ({mem_2_finish, mem_1_finish} !== 2'b10) begin bad++; $display("FAIL cont_p2_first got=%b exp=10", {mem_2_finish, mem_1_finish}); end
    total++; if (mem_2_r !== 32'hAAAA_5555) begin bad++; $display("FAIL cont_p2_data got=%h exp=aaaa5555", mem_2_r); end
    mem_2_r_en = 1'b0;
    tick;
    total++; if ({axi_arvalid, mem_1_finish, mem_2_finish} !== 3'b000) begin
      bad++; $display("FAIL cont_idle got=%b exp=000", {axi_arvalid, mem_1_finish, mem_2_finish}); end
    tick;
    total++; if ({axi_arvalid, axi_araddr} !== {1'b1, 32'h8000_0100}) begin
      bad++; $display("FAIL cont_second_ar got=%h exp=180000100", {axi_arvalid, axi_araddr}); end
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h5555_AAAA;
    tick;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    total++; if ({mem_1_finish, mem_2_finish} !== 2'b10) begin bad++; $display("FAIL cont_p1_second got=%b exp=10", {mem_1_finish, mem_2_finish}); end
    total++; if ({mem_1_r, mem_2_r} !== {32'h5555_AAAA, 32'hAAAA_5555}) begin
      bad++; $display("FAIL cont_data got=%h exp=5555aaaaaaaa5555", {mem_1_r, mem_2_r}); end
    mem_1_r_en = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid();
    mem_1_addr = 32'h8000_0200; mem_1_r_en = 1'b1;
    tick;
    total++; if (axi_arvalid !== 1'b1) begin bad++; $display("FAIL rstmid_arvalid got=%b exp=1", axi_arvalid); end
    #1 rst = 1'b1;
    #1;
    total++; if ({axi_arvalid, axi_rready} !== 2'b00) begin bad++; $display("FAIL rstmid_clear got=%b exp=00", {axi_arvalid, axi_rready}); end
    total++; if (mem_1_r !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", mem_1_r); end
    rst = 1'b0;
    tick;
    total++; if ({axi_arvalid, axi_araddr} !== {1'b1, 32'h8000_0200}) begin
      bad++; $display("FAIL rstmid_regrant got=%h exp=180000200", {axi_arvalid, axi_araddr}); end
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h0BAD_F00D;
    tick;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    total++; if ({mem_1_finish, mem_1_r} !== {1'b1, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL rstmid_complete got=%h exp=10badf00d", {mem_1_finish, mem_1_r}); end
    mem_1_r_en = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back();
    mem_1_addr = 32'h8000_0300; mem_1_r_en = 1'b1;
    tick;
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h1111_1111;
    tick;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    total++; if ({mem_1_finish, mem_1_r} !== {1'b1, 32'h1111_1111}) begin
      bad++; $display("FAIL b2b_first got=%h exp=111111111", {mem_1_finish, mem_1_r}); end
    mem_1_r_en = 1'b0;
    tick;
    total++; if ({mem_1_finish, axi_arvalid} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b exp=00", {mem_1_finish, axi_arvalid}); end
    mem_1_addr = 32'h8000_0304; mem_1_r_en = 1'b1;
    tick;
    total++; if ({axi_arvalid, axi_araddr, mem_1_finish} !== {1'b1, 32'h8000_0304, 1'b0}) begin
      bad++; $display("FAIL b2b_regrant got=%h exp=300000608", {axi_arvalid, axi_araddr, mem_1_finish}); end
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rdata = 32'h2222_2222;
    tick;
    axi_arready = 1'b0; axi_rvalid = 1'b0;
    total++; if ({mem_1_finish, mem_1_r} !== {1'b1, 32'h2222_2222}) begin
      bad++; $display("FAIL b2b_second got=%h exp=122222222", {mem_1_finish, mem_1_r}); end
    mem_1_r_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if ({mem_1_finish, mem_2_finish, axi_arvalid} !== 3'b000) begin
        bad++; $display("FAIL b2b_spurious%0d got=%b exp=000", i, {mem_1_finish, mem_2_finish, axi_arvalid}); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_axi_arbiter.md
Name: mem_axi_arbiter

Overview:
- Memory controller between the CPU core and a single AXI4-Lite slave (SRAM model).
- Port 1 is instruction fetch (read-only); port 2 is load/store (read/write, byte mask).
- Arbitrates the two ports onto one AXI4-Lite master interface and serves one transaction at a time.
- Returns raw 32-bit words; sub-word extraction and sign extension are done in the core.

Parameters:
- XLEN, 32, address/data width (shared package constant ISA_WIDTH).
- MASK_W, 4, write-strobe width (shared package constant MEM_MASK_WIDTH).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_1_r  out  XLEN  fetch read data, valid when mem_1_finish=1, held afterwards
- mem_1_addr  in  XLEN  fetch address
- mem_1_r_en  in  1  fetch request, level, held until mem_1_finish
- mem_1_finish  out  1  one-cycle completion pulse for port 1
- mem_2_r  out  XLEN  load data, valid when mem_2_finish=1, held afterwards
- mem_2_w  in  XLEN  store data
- mem_2_addr  in  XLEN  load/store address
- mem_2_mask  in  MASK_W  store byte strobes
- mem_2_r_en  in  1  load request, level, held until mem_2_finish
- mem_2_w_en  in  1  store request, level, held until mem_2_finish
- mem_2_finish  out  1  one-cycle completion pulse for port 2
- axi_araddr  out  XLEN  read address
- axi_arvalid  out  1  read-address valid
- axi_arready  in  1  read-address ready
- axi_rdata  in  XLEN  read data
- axi_rresp  in  XLEN  read response, ignored
- axi_rvalid  in  1  read-data valid
- axi_rready  out  1  read-data ready
- axi_awaddr  out  XLEN  write address
- axi_awvalid  out  1  write-address valid
- axi_awready  in  1  write-address ready
- axi_wdata  out  XLEN  write data
- axi_wstrb  out  MASK_W  write strobes
- axi_wvalid  out  1  write-data valid
- axi_wready  in  1  write-data ready
- axi_bresp  in  XLEN  write response, ignored
- axi_bvalid  in  1  write-response valid
- axi_bready  out  1  write-response ready

Behaviour:
- Reset: state=IDLE.
  - All valid/ready outputs, finish pulses and data outputs = 0.
  - All address, data and strobe registers = 0.
- All outputs are driven from registers.
- States: IDLE, RD, WR, FIN.
- IDLE arbitration, fixed priority:
  - mem_2_w_en goes to WR.
  - Else mem_2_r_en goes to RD with source=2.
  - Else mem_1_r_en goes to RD with source=1.
  - mem_2_w_en and mem_2_r_en together is treated as a write.
  - A granted transaction is never preempted.
- On grant, latch addr, wdata, wstrb and source.
  - In the next cycle arvalid, or awvalid and wvalid, is asserted.
- RD:
  - arvalid stays 1 until the cycle arvalid&&arready, then drops to 0.
  - rready=1 throughout RD.
  - On rvalid&&rready, latch rdata into mem_1_r or mem_2_r by source, then go to FIN.
  - rvalid may arrive in the same cycle as the AR handshake or later.
- WR:
  - awvalid and wvalid are asserted together; each drops independently after its own handshake.
  - bready=1 throughout WR.
  - On bvalid&&bready, go to FIN.
  - B accepted before both AW and W handshakes complete is a protocol error; ignore such B.
- FIN:
  - Assert the finish pulse of the source port for exactly one cycle, then go to IDLE.
  - A store drives mem_2_finish; mem_2_r is unchanged.
- Requester contract: deassert the enable at the edge where finish=1 is seen. A request re-asserted in the IDLE cycle is accepted.
- Minimum latency with a zero-wait slave:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: valid asserted.
  - Cycle 2 or later: R/B handshake.
  - Cycle after the handshake: finish.
- rresp/bresp are not checked; finish is issued regardless.
- Async rst mid-transaction returns to IDLE immediately and clears all outputs; the pending request is lost.
- Address alignment is not checked here.

Decomposition:
- Shared package: ISA_WIDTH=32, MEM_MASK_WIDTH=4, the state encoding, and source-select encoding.
- No sub-module needed.
- The optional single-port AXI-Lite channel FSM may be factored as axi_lite_master_fsm; the arbiter stays in the top.

Test Plan:
- Fetch: mem_1_r_en=1, addr=0x80000000; slave returns 0x00100073 after 2 wait cycles -> araddr=0x80000000 and arvalid held until arready; mem_1_finish single pulse; mem_1_r=0x00100073; mem_2_finish=0.
- Store: w_en=1, addr=0x80001004, w=0xDEADBEEF, mask=4'b0011; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 handshake, awvalid after the 3rd cycle; mem_2_finish one cycle after bvalid.
- Load: r_en=1, addr=0x80001004, rdata=0x1234ABCD -> mem_2_r=0x1234ABCD on the finish pulse; mem_1_r unchanged.
- Contention: mem_1_r_en and mem_2_r_en raised in the same cycle -> port 2 served first, then port 1 after its finish; mem_2_finish precedes mem_1_finish.
- Reset mid-read: rst pulses while arvalid=1 -> arvalid=0 and state=IDLE immediately; a new fetch then completes normally.
- Back-to-back: fetch re-asserted in the IDLE cycle after finish -> new arvalid the next cycle; no spurious finish.
